vpf_serializer: RTL
===================

Name: vpf_serializer

Overview:
- Reads back a latched VPF vector of SIZE bits, the same vector the cluster counter sums.
- Emits the index of every set bit, lowest index first, one per cycle, on a valid/ready stream.
- Stops at MAX_CLUSTERS and flags overflow when set bits remain.
- Its final emitted count is directly comparable to the pipelined cluster count. It feeds cluster packing and readout paths that need addresses, not just a total.

Parameters:
- SIZE, 768, width of VPF vector; supported values are 768 and 1536.
- MAX_CLUSTERS, 16, maximum addresses emitted per latch; range 1..SIZE.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- latch  in  1  capture vpfs_i and start a scan; honoured only in IDLE.
- vpfs_i  in  SIZE  valid pattern flags; bit i corresponds to address i.
- busy_o  out  1  high whenever state is not IDLE.
- adr_o  out  11  address (bit index) of the current set bit.
- valid_o  out  1  adr_o is valid.
- ready_i  in  1  downstream accepts adr_o this cycle.
- last_o  out  1  qualifies adr_o as the final word of this scan.
- done_o  out  1  one-cycle pulse at end of scan.
- cnt_o  out  11  number of addresses emitted this scan.
- overflow_o  out  1  set bits remained after MAX_CLUSTERS emitted.

Behaviour:
- Async reset behaviour:
  - State goes to IDLE; work register is cleared.
  - adr_o, valid_o, last_o, done_o, cnt_o, overflow_o and busy_o are all 0.
  - Reset asserted mid-scan aborts immediately; no partial word survives.
- States are IDLE, SCAN and DONE.
- IDLE with latch=1 at edge N:
  - Load vpfs_i into the work register.
  - Clear cnt_o and overflow_o.
  - Enter SCAN.
- IDLE with latch=0: hold; cnt_o and overflow_o keep their last scan's values.
- latch while busy_o=1: ignored, with no effect on the work register, counters or stream.
- SCAN output slot and load rule:
  - One output register (adr_o, valid_o, last_o) forms the slot.
  - The slot is free when valid_o=0 or valid_o&ready_i.
  - When the slot is free, any work bit is set, and cnt_o<MAX_CLUSTERS:
    - load adr_o with the lowest set index;
    - clear that work bit;
    - cnt_o+=1;
    - valid_o=1.
  - last_o=1 on the loaded word if no other work bit remains, or if cnt_o after the increment equals MAX_CLUSTERS.
- While valid_o=1 and ready_i=0, adr_o and last_o are held stable.
- SCAN exit:
  - When the slot is free and either no work bits remain or cnt_o==MAX_CLUSTERS, clear valid_o and go to DONE.
  - overflow_o is set at that edge iff work bits remain.
- DONE: done_o=1 for exactly one cycle, then IDLE next edge.
- Latency and throughput:
  - First valid_o is high after edge N+1.
  - With ready_i held high, one address per cycle.
  - k addresses (k≤MAX_CLUSTERS): last accepted at edge N+k+1, DONE entered at that same edge, done_o high in cycle after edge N+k+1.
- Empty vector: SCAN sees no bits and an empty slot, so DONE is entered at edge N+1. No valid_o, cnt_o=0, overflow_o=0.
- The priority encoder may be pipelined internally only if the throughput and latency above are preserved.
- Widths:
  - cnt_o saturates never, since MAX_CLUSTERS≤SIZE≤1536<2048.
  - adr_o upper bits are 0 for SIZE=768.
- Boundaries:
  - Bit 0 and bit SIZE-1 must both be emitted.
  - If the set-bit count equals MAX_CLUSTERS exactly, overflow_o=0 and last_o is on word MAX_CLUSTERS.
  - If ready_i is deasserted on the last word, DONE waits for acceptance.

Test Plan:
- SIZE=768, vpfs bit 5 only, ready_i=1 -> single word adr_o=5 with last_o=1 valid after edge N+1; done_o pulse; cnt_o=1, overflow_o=0.
- Bits {0, 383, 767} -> adr_o sequence 0, 383, 767 on consecutive cycles; last_o only on 767; cnt_o=3.
- All-zero vector -> no valid_o; done_o in cycle after edge N+1; cnt_o=0, overflow_o=0.
- 20 bits set at indices 0..19, MAX_CLUSTERS=16 -> addresses 0..15 emitted, last_o on 15; overflow_o=1, cnt_o=16.
- Bits {10, 20}, ready_i low 3 cycles while adr_o=10 is presented -> adr_o holds 10 with valid_o=1; after ready_i rises, 20 follows next cycle; no duplicates or drops.
- latch pulses while busy_o=1 -> ignored, and the original scan completes unchanged.
- Reset asserted during a scan -> all outputs 0 immediately; a new latch then scans normally from scratch.
- SIZE=1536 with bit 1535 set -> adr_o=1535.

Source files
------------

// File: rtl/vpf_serializer.sv
// vpf_serializer: walks a latched VPF vector and streams the index
// of each set bit, lowest first, capped at MAX_CLUSTERS per scan.
module vpf_serializer #(
    parameter int SIZE         = 768,
    parameter int MAX_CLUSTERS = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            latch,
    input  logic [SIZE-1:0] vpfs_i,
    output logic            busy_o,
    output logic [10:0]     adr_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            last_o,
    output logic            done_o,
    output logic [10:0]     cnt_o,
    output logic            overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [10:0]     MAXC = 11'(MAX_CLUSTERS);
    localparam logic [SIZE-1:0] ONE  = SIZE'(1);

    state_t          r_state;
    state_t          w_next;
    logic [SIZE-1:0] r_work;
    logic [10:0]     r_adr;
    logic            r_valid;
    logic            r_last;
    logic [10:0]     r_cnt;
    logic            r_ovf;

    logic [10:0]     w_idx;
    logic [SIZE-1:0] w_rest;
    logic [10:0]     w_cnt_inc;
    logic            w_any;
    logic            w_room;
    logic            w_free;
    logic            w_load;
    logic            w_exit;

    // Lowest set index of the work register; the scan runs high to low
    // so the final assignment is the lowest hit.
    always_comb begin
        w_idx = 11'd0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (r_work[i]) w_idx = 11'(i);
        end
    end

    assign w_rest    = r_work & (r_work - ONE);
    assign w_cnt_inc = r_cnt + 11'd1;
    assign w_any     = |r_work;
    assign w_room    = (r_cnt < MAXC);
    assign w_free    = !r_valid || ready_i;
    assign w_load    = (r_state == S_SCAN) && w_free && w_any && w_room;
    assign w_exit    = (r_state == S_SCAN) && w_free && !(w_any && w_room);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (latch) w_next = S_SCAN;
            S_SCAN:  if (w_exit) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_o = (r_state != S_IDLE);
        done_o = (r_state == S_DONE);
    end

    // Work register, output slot and per-scan counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_work  <= '0;
            r_adr   <= 11'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= 11'd0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (latch) begin
                r_work <= vpfs_i;
                r_cnt  <= 11'd0;
                r_ovf  <= 1'b0;
            end
        end else if (w_load) begin
            r_adr   <= w_idx;
            r_work  <= w_rest;
            r_cnt   <= w_cnt_inc;
            r_valid <= 1'b1;
            r_last  <= (w_rest == '0) || (w_cnt_inc == MAXC);
        end else if (w_exit) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= w_any;
        end
    end

    assign adr_o      = r_adr;
    assign valid_o    = r_valid;
    assign last_o     = r_last;
    assign cnt_o      = r_cnt;
    assign overflow_o = r_ovf;

endmodule
